// File: rtl/byte_seq_ctrl.sv
// Sequencing controller that holds one 128-bit word and streams its byte lanes
// in ascending or descending order over a valid/ready interface, with last/done markers.
module byte_seq_ctrl #(
  parameter int NLANE = 16,
  parameter int BW    = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_valid_i,
  output logic                  load_ready_o,
  input  logic [NLANE*BW-1:0]   load_data_i,
  input  logic [3:0]            load_len_i,
  input  logic                  load_dir_i,
  input  logic                  abort_i,
  output logic [3:0]            sel_o,
  output logic [BW-1:0]         out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  out_last_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t                state_q;
  logic [NLANE*BW-1:0]   holdWord_q;
  logic [3:0]            sel_q;
  logic [3:0]            cnt_q;
  logic                  dir_q;
  logic                  done_q;

  logic                  streaming;
  logic                  lastBeat;
  logic                  beatFire;
  logic                  loadFire;

  // A beat is only counted as transferred when abort is low in the same cycle.
  always_comb begin
    streaming    = (state_q == STREAM);
    lastBeat     = (cnt_q == 4'd0);
    beatFire     = streaming && out_ready_i && !abort_i && !rst_i;
    load_ready_o = !rst_i && !abort_i &&
                   (!streaming || (out_ready_i && lastBeat));
    loadFire     = load_valid_i && load_ready_o;
  end

  assign out_valid_o = streaming;
  assign out_last_o  = streaming && lastBeat;
  assign busy_o      = streaming;
  assign sel_o       = sel_q;
  assign done_o      = done_q;
  assign out_data_o  = holdWord_q[sel_q*BW +: BW];

  // Single FSM register block; priority is reset, then abort, then load, then beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      holdWord_q <= '0;
      sel_q      <= 4'd0;
      cnt_q      <= 4'd0;
      dir_q      <= 1'b0;
      done_q     <= 1'b0;
    end else if (abort_i) begin
      state_q <= IDLE;
      sel_q   <= 4'd0;
      cnt_q   <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      done_q <= beatFire && lastBeat;
      if (loadFire) begin
        state_q    <= STREAM;
        holdWord_q <= load_data_i;
        cnt_q      <= load_len_i;
        dir_q      <= load_dir_i;
        sel_q      <= load_dir_i ? load_len_i : 4'd0;
      end else if (beatFire) begin
        if (lastBeat) begin
          state_q <= IDLE;
        end else begin
          cnt_q <= cnt_q - 4'd1;
          sel_q <= dir_q ? (sel_q - 4'd1) : (sel_q + 4'd1);
        end
      end
    end
  end

endmodule

// File: tb/tb_byte_seq_ctrl.sv
// Directed self-checking bench for byte_seq_ctrl: reset, ascending, descending,
// backpressure, back-to-back and abort scenarios with hand-computed expectations.
module tb_byte_seq_ctrl;

  logic         clk;
  logic         rst;
  logic         loadValid;
  logic         loadReady;
  logic [127:0] loadData;
  logic [3:0]   loadLen;
  logic         loadDir;
  logic         abortIn;
  logic [3:0]   sel;
  logic [7:0]   outData;
  logic         outValid;
  logic         outReady;
  logic         outLast;
  logic         busy;
  logic         done;

  int errors;
  int checks;

  localparam logic [127:0] ASC_WORD = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] AA_WORD  = {16{8'hAA}};

  byte_seq_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .load_valid_i (loadValid),
    .load_ready_o (loadReady),
    .load_data_i  (loadData),
    .load_len_i   (loadLen),
    .load_dir_i   (loadDir),
    .abort_i      (abortIn),
    .sel_o        (sel),
    .out_data_o   (outData),
    .out_valid_o  (outValid),
    .out_ready_i  (outReady),
    .out_last_o   (outLast),
    .busy_o       (busy),
    .done_o       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle 1ns past the rising edge before driving or sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    loadValid = 1'b1;
    loadData  = ASC_WORD;
    loadLen   = 4'd5;
    loadDir   = 1'b0;
    abortIn   = 1'b0;
    outReady  = 1'b1;
    repeat (3) tick();
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", outValid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %0b expected 0", done); end
    checks++; if (sel !== 4'd0) begin errors++; $display("[TB] FAIL reset_sel: got %0d expected 0", sel); end
    checks++; if (outLast !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_last: got %0b expected 0", outLast); end
    checks++; if (outData !== 8'h00) begin errors++; $display("[TB] FAIL reset_out_data: got %0h expected 00", outData); end
    checks++; if (loadReady !== 1'b0) begin errors++; $display("[TB] FAIL reset_load_ready: got %0b expected 0", loadReady); end
    rst       = 1'b0;
    loadValid = 1'b0;
    #1;
    checks++; if (loadReady !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_load_ready: got %0b expected 1", loadReady); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_busy: got %0b expected 0", busy); end
    checks++; if (loadReady !== 1'b1) begin errors++; $display("[TB] FAIL idle_load_ready: got %0b expected 1", loadReady); end
  endtask

  task automatic test_ascending();
    loadData  = ASC_WORD;
    loadLen   = 4'd15;
    loadDir   = 1'b0;
    outReady  = 1'b1;
    loadValid = 1'b1;
    tick();
    loadValid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++; if (outValid !== 1'b1) begin errors++; $display("[TB] FAIL asc_valid[%0d]: got %0b expected 1", i, outValid); end
      checks++; if (outData !== 8'(i)) begin errors++; $display("[TB] FAIL asc_data[%0d]: got %0h expected %0h", i, outData, 8'(i)); end
      checks++; if (sel !== 4'(i)) begin errors++; $display("[TB] FAIL asc_sel[%0d]: got %0d expected %0d", i, sel, i); end
      checks++; if (outLast !== (i == 15)) begin errors++; $display("[TB] FAIL asc_last[%0d]: got %0b expected %0b", i, outLast, (i == 15)); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL asc_done_early[%0d]: got %0b expected 0", i, done); end
      tick();
    end
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL asc_done: got %0b expected 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL asc_busy_end: got %0b expected 0", busy); end
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL asc_valid_end: got %0b expected 0", outValid); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL asc_done_width: got %0b expected 0", done); end
  endtask

  task automatic test_descending();
    loadData  = ASC_WORD;
    loadLen   = 4'd3;
    loadDir   = 1'b1;
    outReady  = 1'b1;
    loadValid = 1'b1;
    tick();
    loadValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (sel !== 4'(3 - i)) begin errors++; $display("[TB] FAIL desc_sel[%0d]: got %0d expected %0d", i, sel, 3 - i); end
      checks++; if (outData !== 8'(3 - i)) begin errors++; $display("[TB] FAIL desc_data[%0d]: got %0h expected %0h", i, outData, 8'(3 - i)); end
      checks++; if (outLast !== (i == 3)) begin errors++; $display("[TB] FAIL desc_last[%0d]: got %0b expected %0b", i, outLast, (i == 3)); end
      tick();
    end
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL desc_done: got %0b expected 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL desc_busy_end: got %0b expected 0", busy); end
    tick();
  endtask

  task automatic test_backpressure();
    int k;
    int c;
    loadData  = ASC_WORD;
    loadLen   = 4'd4;
    loadDir   = 1'b0;
    outReady  = 1'b1;
    loadValid = 1'b1;
    tick();
    loadValid = 1'b0;
    k = 0;
    c = 0;
    while (k < 5 && c < 40) begin
      outReady = (c % 3 == 0);
      #1;
      checks++; if (outData !== 8'(k)) begin errors++; $display("[TB] FAIL bp_data[c%0d]: got %0h expected %0h", c, outData, 8'(k)); end
      checks++; if (sel !== 4'(k)) begin errors++; $display("[TB] FAIL bp_sel[c%0d]: got %0d expected %0d", c, sel, k); end
      checks++; if (outLast !== (k == 4)) begin errors++; $display("[TB] FAIL bp_last[c%0d]: got %0b expected %0b", c, outLast, (k == 4)); end
      checks++; if (loadReady !== (outReady && k == 4)) begin errors++; $display("[TB] FAIL bp_load_ready[c%0d]: got %0b expected %0b", c, loadReady, (outReady && k == 4)); end
      if (outReady) k++;
      c++;
      tick();
    end
    checks++; if (k !== 5) begin errors++; $display("[TB] FAIL bp_beat_count: got %0d expected 5 (cycle budget)", k); end
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL bp_done: got %0b expected 1", done); end
    outReady = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    loadData  = ASC_WORD;
    loadLen   = 4'd2;
    loadDir   = 1'b0;
    outReady  = 1'b1;
    loadValid = 1'b1;
    tick();
    loadValid = 1'b0;
    #1;
    checks++; if (loadReady !== 1'b0) begin errors++; $display("[TB] FAIL b2b_mid_load_ready: got %0b expected 0", loadReady); end
    tick();
    tick();
    loadData  = AA_WORD;
    loadLen   = 4'd1;
    loadDir   = 1'b0;
    loadValid = 1'b1;
    #1;
    checks++; if (outData !== 8'h02) begin errors++; $display("[TB] FAIL b2b_first_last_data: got %0h expected 02", outData); end
    checks++; if (loadReady !== 1'b1) begin errors++; $display("[TB] FAIL b2b_load_ready: got %0b expected 1", loadReady); end
    tick();
    loadValid = 1'b0;
    loadData  = ASC_WORD;
    checks++; if (outValid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_no_bubble: got %0b expected 1", outValid); end
    checks++; if (outData !== 8'hAA) begin errors++; $display("[TB] FAIL b2b_data0: got %0h expected aa", outData); end
    checks++; if (sel !== 4'd0) begin errors++; $display("[TB] FAIL b2b_sel0: got %0d expected 0", sel); end
    checks++; if (outLast !== 1'b0) begin errors++; $display("[TB] FAIL b2b_last0: got %0b expected 0", outLast); end
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done1: got %0b expected 1", done); end
    tick();
    checks++; if (outData !== 8'hAA) begin errors++; $display("[TB] FAIL b2b_data1: got %0h expected aa", outData); end
    checks++; if (sel !== 4'd1) begin errors++; $display("[TB] FAIL b2b_sel1: got %0d expected 1", sel); end
    checks++; if (outLast !== 1'b1) begin errors++; $display("[TB] FAIL b2b_last1: got %0b expected 1", outLast); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done_gap: got %0b expected 0", done); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done2: got %0b expected 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_busy_end: got %0b expected 0", busy); end
    tick();
  endtask

  task automatic test_abort();
    loadData  = ASC_WORD;
    loadLen   = 4'd15;
    loadDir   = 1'b0;
    outReady  = 1'b1;
    loadValid = 1'b1;
    tick();
    loadValid = 1'b0;
    tick();
    tick();
    abortIn = 1'b1;
    #1;
    checks++; if (outData !== 8'h02) begin errors++; $display("[TB] FAIL abort_beat2_data: got %0h expected 02", outData); end
    checks++; if (loadReady !== 1'b0) begin errors++; $display("[TB] FAIL abort_load_ready: got %0b expected 0", loadReady); end
    tick();
    abortIn = 1'b0;
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL abort_valid: got %0b expected 0", outValid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %0b expected 0", busy); end
    checks++; if (sel !== 4'd0) begin errors++; $display("[TB] FAIL abort_sel: got %0d expected 0", sel); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL abort_done: got %0b expected 0", done); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL abort_done_late: got %0b expected 0", done); end
    loadData  = 128'h00000000000000000000000000005A3C;
    loadLen   = 4'd1;
    loadValid = 1'b1;
    tick();
    loadValid = 1'b0;
    checks++; if (outData !== 8'h3C) begin errors++; $display("[TB] FAIL post_abort_data0: got %0h expected 3c", outData); end
    checks++; if (sel !== 4'd0) begin errors++; $display("[TB] FAIL post_abort_sel0: got %0d expected 0", sel); end
    tick();
    checks++; if (outData !== 8'h5A) begin errors++; $display("[TB] FAIL post_abort_data1: got %0h expected 5a", outData); end
    checks++; if (outLast !== 1'b1) begin errors++; $display("[TB] FAIL post_abort_last: got %0b expected 1", outLast); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL post_abort_done: got %0b expected 1", done); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    $display("[TB] starting byte_seq_ctrl bench");
    test_reset();
    test_ascending();
    test_descending();
    test_backpressure();
    test_back_to_back();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
